// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//
// Instruction buffer between the fetch stage and the decoder. Fetch pushes
// {PC, instruction} pairs in program order. The decoder reads the head entry
// combinationally. The buffer absorbs i-cache hit timing against decode
// stalls, and a flush squashes everything queued.
//
// Ports
//   clk        core clock, all state updates on the rising edge
//   rst        asynchronous active-low reset (rst==0 resets)
//   in_valid   fetch presents a valid instruction
//   in_ready   queue can accept (count < DEPTH)
//   in_inst    fetched instruction word
//   in_pc      PC of in_inst
//   flush      squash all entries (mispredict / exception)
//   out_valid  head entry valid (count != 0)
//   out_ready  decoder consumes the head this cycle
//   out_inst   head instruction (0 when empty)
//   out_pc     head PC (0 when empty)
//   count      current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int ARCH_BITS = 32,
    parameter int DEPTH     = 4,
    parameter int CNT_BITS  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ARCH_BITS-1:0] in_inst,
    input  logic [ARCH_BITS-1:0] in_pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ARCH_BITS-1:0] out_inst,
    output logic [ARCH_BITS-1:0] out_pc,
    output logic [CNT_BITS-1:0]  count
);

    localparam int PTR_BITS = $clog2(DEPTH);

    logic [ARCH_BITS-1:0] r_mem_inst [DEPTH];
    logic [ARCH_BITS-1:0] r_mem_pc   [DEPTH];
    logic [PTR_BITS-1:0]  r_wr_ptr;
    logic [PTR_BITS-1:0]  r_rd_ptr;
    logic [CNT_BITS-1:0]  r_count;

    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;

    // Ready is taken from the registered count alone, so a full queue
    // refuses a push even when the decoder pops in the same cycle.
    assign w_full    = (r_count == CNT_BITS'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;
    assign w_push    = in_valid & ~w_full;
    assign w_pop     = ~w_empty & out_ready;
    assign count     = r_count;

    // An empty queue shows an all-zero bubble rather than stale storage.
    assign out_inst = w_empty ? '0 : r_mem_inst[r_rd_ptr];
    assign out_pc   = w_empty ? '0 : r_mem_pc[r_rd_ptr];

    // Entry storage is not reset; occupancy alone decides what is visible.
    // A push during flush may land in storage but is never made visible,
    // because the pointers and count are cleared on the same edge.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= in_inst;
            r_mem_pc[r_wr_ptr]   <= in_pc;
        end
    end

    // Flush beats any handshake in the same cycle. Pointers are exactly
    // log2(DEPTH) bits so they wrap on their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_BITS'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Directed bench for inst_fetch_queue (DEPTH=4, ARCH_BITS=32). Inputs change
// on the falling edge and outputs are sampled on the falling edge. Expected
// head order comes from a small queue of pushed {pc, inst} pairs.
// ---------------------------------------------------------------------------
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int vectors;
    int miscompares;
    logic [63:0] expQ[$];

    inst_fetch_queue #(
        .ARCH_BITS(32),
        .DEPTH    (4),
        .CNT_BITS (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_inst  (in_inst),
        .in_pc    (in_pc),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst (out_inst),
        .out_pc   (out_pc),
        .count    (count)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison point: counts the vector and flags a miscompare.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it, and return at the next falling edge.
    task automatic applyStimulus(input logic iv, input logic [31:0] inst,
                                 input logic [31:0] pc, input logic ordy,
                                 input logic fl);
        in_valid  = iv;
        in_inst   = inst;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model update for one edge, given the handshakes that held
    // before it (the bench computes them from its own expected occupancy).
    task automatic modelEdge(input logic pushOk, input logic popOk,
                             input logic [31:0] inst, input logic [31:0] pc);
        if (popOk) void'(expQ.pop_front());
        if (pushOk) expQ.push_back({pc, inst});
    endtask

    initial begin
        logic [31:0] inst;
        logic [31:0] pc;
        logic [63:0] head;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_inst     = '0;
        in_pc       = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;

        // Held in reset.
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_out_inst", out_inst, 32'h0);
        checkOutput("rst_out_pc", out_pc, 32'h0);

        // Release and idle.
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
        checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_count", 32'(count), 32'd0);

        // Single push: not visible before the edge, visible after it.
        in_valid = 1'b1;
        in_inst  = 32'h0A00_0000;
        in_pc    = 32'h100;
        #1;
        checkOutput("nobypass_out_valid", 32'(out_valid), 32'd0);
        checkOutput("nobypass_out_inst", out_inst, 32'h0);
        applyStimulus(1'b1, 32'h0A00_0000, 32'h100, 1'b0, 1'b0);
        in_valid = 1'b0;
        checkOutput("push1_out_valid", 32'(out_valid), 32'd1);
        checkOutput("push1_out_inst", out_inst, 32'h0A00_0000);
        checkOutput("push1_out_pc", out_pc, 32'h100);
        checkOutput("push1_count", 32'(count), 32'd1);

        // Empty it with a flush before the fill test.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("flush1_count", 32'(count), 32'd0);
        checkOutput("flush1_out_valid", 32'(out_valid), 32'd0);

        // Five back-to-back pushes with the decoder stalled.
        for (int i = 0; i < 5; i++) begin
            inst = 32'h1000 + 32'(i);
            pc   = 32'h200 + 32'(4 * i);
            in_valid = 1'b1;
            in_inst  = inst;
            in_pc    = pc;
            out_ready = 1'b0;
            #1;
            checkOutput($sformatf("fill_in_ready_%0d", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
            modelEdge(i < 4, 1'b0, inst, pc);
            applyStimulus(1'b1, inst, pc, 1'b0, 1'b0);
        end
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("full_hold_inst", out_inst, 32'h1000);
        checkOutput("full_hold_pc", out_pc, 32'h200);

        // Full, fifth entry re-presented, decoder ready: pop only.
        modelEdge(1'b0, 1'b1, 32'h1004, 32'h210);
        applyStimulus(1'b1, 32'h1004, 32'h210, 1'b1, 1'b0);
        checkOutput("popfull_count", 32'(count), 32'd3);
        checkOutput("popfull_head", out_inst, 32'h1001);

        // Steady push&pop across pointer wrap; head follows push order.
        for (int i = 0; i < 12; i++) begin
            inst = 32'h1004 + 32'(i);
            pc   = 32'h200 + 32'(4 * (4 + i));
            head = expQ[0];
            in_valid  = 1'b1;
            in_inst   = inst;
            in_pc     = pc;
            out_ready = 1'b1;
            #1;
            checkOutput($sformatf("steady_in_ready_%0d", i), 32'(in_ready), 32'd1);
            checkOutput($sformatf("steady_inst_%0d", i), out_inst, head[31:0]);
            checkOutput($sformatf("steady_pc_%0d", i), out_pc, head[63:32]);
            modelEdge(1'b1, 1'b1, inst, pc);
            applyStimulus(1'b1, inst, pc, 1'b1, 1'b0);
            checkOutput($sformatf("steady_count_%0d", i), 32'(count), 32'd3);
        end

        // Flush with three entries, while pushing and popping.
        applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h400, 1'b1, 1'b1);
        expQ.delete();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        checkOutput("flush_out_inst", out_inst, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("postflush_count", 32'(count), 32'd0);

        // Two entries, then asynchronous reset mid-cycle.
        applyStimulus(1'b1, 32'h2000, 32'h500, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2001, 32'h504, 1'b0, 1'b0);
        in_valid = 1'b0;
        checkOutput("prerst_count", 32'(count), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // First push after release is alone at the head.
        applyStimulus(1'b1, 32'h3000, 32'h600, 1'b0, 1'b0);
        in_valid = 1'b0;
        checkOutput("afterrst_count", 32'(count), 32'd1);
        checkOutput("afterrst_inst", out_inst, 32'h3000);
        checkOutput("afterrst_pc", out_pc, 32'h600);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        out_ready = 1'b0;
        checkOutput("afterrst_drain_valid", 32'(out_valid), 32'd0);
        checkOutput("afterrst_drain_count", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
